// File: rtl/icache_refill_ctrl.sv
// Refill sequencer for a 2-way I-cache: on a fetch miss, invalidate the victim, burst-read the line, revalidate.
// Latency: miss_req to arvalid 2 cycles; last beat to refill_done 2 cycles (1 on error); flush takes S*N cycles.
// Backpressure: arvalid is held until arready; rready is high for the whole data phase; requests are ignored while busy.
module icache_refill_ctrl #(
   parameter int N = 2,
   parameter int B = 8,
   parameter int S = 64
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                miss_req,
   input  logic [63:0]                         miss_addr,
   input  logic                                flush_req,
   input  logic                                lru_rd,
   input  logic [N-1:0]                        valid_rd,
   output logic                                arvalid,
   input  logic                                arready,
   output logic [63:0]                         araddr,
   output logic [7:0]                          arlen,
   output logic [2:0]                          arsize,
   output logic [1:0]                          arburst,
   input  logic                                rvalid,
   output logic                                rready,
   input  logic [63:0]                         rdata,
   input  logic [1:0]                          rresp,
   input  logic                                rlast,
   output logic                                data_we,
   output logic [$clog2(S)-1:0]                data_set,
   output logic                                data_way,
   output logic [$clog2(B)-1:0]                data_word,
   output logic [63:0]                         data_wdata,
   output logic                                tag_we,
   output logic [$clog2(S)-1:0]                tag_set,
   output logic                                tag_way,
   output logic [64-$clog2(S)-$clog2(B)-3:0]   tag_wdata,
   output logic                                refill_done,
   output logic                                refill_err,
   output logic                                busy
);
   localparam int SB = $clog2(S);
   localparam int BB = $clog2(B);
   localparam int YB = 3;
   localparam int TB = 64 - SB - BB - YB;
   localparam int LB = 64 - BB - YB;
   localparam int FB = $clog2(S * N);
   localparam logic [BB-1:0] LAST_BEAT  = BB'(B - 1);
   localparam logic [FB-1:0] LAST_ENTRY = FB'(S * N - 1);

   typedef enum logic [2:0] {IDLE, INV, AR, RDATA, TAG, DONE, FLUSH} state_t;

   state_t          state, state_nxt;
   logic [LB-1:0]   line_q;
   logic [SB-1:0]   set_q;
   logic [TB-1:0]   tag_q;
   logic            victim_q;
   logic            victim;
   logic [BB-1:0]   beat_q;
   logic            err_q;
   logic [FB-1:0]   fcnt_q;
   logic            unused_addr_lsb;

   // byte/word offset bits of the PC never reach the AXI address or the arrays
   assign unused_addr_lsb = ^miss_addr[BB+YB-1:0];

   assign arlen   = 8'(B - 1);
   assign arsize  = 3'b011;
   assign arburst = 2'b01;
   assign araddr  = {line_q, {(BB+YB){1'b0}}};

   // victim: first invalid way wins, otherwise fall back to the LRU way
   always_comb begin
      victim = lru_rd;
      if (!valid_rd[0])
         victim = 1'b0;
      else if (!valid_rd[1])
         victim = 1'b1;
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next-state logic; flush takes priority over a simultaneous miss
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (flush_req)     state_nxt = FLUSH;
                else if (miss_req) state_nxt = INV;
         INV:   state_nxt = AR;
         AR:    if (arready)       state_nxt = RDATA;
         RDATA: if (rvalid && rlast) begin
                   if (beat_q == LAST_BEAT && !err_q && rresp == 2'b00)
                      state_nxt = TAG;
                   else
                      state_nxt = DONE;
                end
         TAG:   state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         FLUSH: if (fcnt_q == LAST_ENTRY) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // captured miss context, beat/flush counters and the sticky error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q   <= '0;
         set_q    <= '0;
         tag_q    <= '0;
         victim_q <= 1'b0;
         beat_q   <= '0;
         err_q    <= 1'b0;
         fcnt_q   <= '0;
      end else begin
         case (state)
            IDLE: if (!flush_req && miss_req) begin
               line_q   <= miss_addr[63:BB+YB];
               set_q    <= miss_addr[BB+YB +: SB];
               tag_q    <= miss_addr[63 -: TB];
               victim_q <= victim;
            end
            RDATA: if (rvalid) begin
               // counter wraps naturally; a short burst or a ninth beat both mark the line bad
               beat_q <= beat_q + 1'b1;
               err_q  <= err_q | (rresp != 2'b00) |
                         (rlast ? (beat_q != LAST_BEAT) : (beat_q == LAST_BEAT));
            end
            FLUSH: fcnt_q <= fcnt_q + 1'b1;
            DONE: begin
               beat_q <= '0;
               err_q  <= 1'b0;
               fcnt_q <= '0;
            end
            default: ;
         endcase
      end
   end

   // state-decoded outputs; write data is gated so nothing toggles outside an accepted beat
   always_comb begin
      arvalid     = 1'b0;
      rready      = 1'b0;
      data_we     = 1'b0;
      data_set    = set_q;
      data_way    = victim_q;
      data_word   = beat_q;
      data_wdata  = '0;
      tag_we      = 1'b0;
      tag_set     = set_q;
      tag_way     = victim_q;
      tag_wdata   = '0;
      refill_done = 1'b0;
      refill_err  = 1'b0;
      busy        = (state != IDLE);
      case (state)
         INV: begin
            tag_we    = 1'b1;
            tag_wdata = {1'b0, tag_q};
         end
         AR: arvalid = 1'b1;
         RDATA: begin
            rready  = 1'b1;
            data_we = rvalid;
            if (rvalid) data_wdata = rdata;
         end
         TAG: begin
            tag_we    = 1'b1;
            tag_wdata = {1'b1, tag_q};
         end
         DONE: begin
            refill_done = 1'b1;
            refill_err  = err_q;
         end
         FLUSH: begin
            tag_we  = 1'b1;
            tag_set = fcnt_q[FB-1:1];
            tag_way = fcnt_q[0];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: directed scenarios plus randomized refills.
// Expected values come from address arithmetic and the burst shape, not from the FSM structure.
module tb_icache_refill_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        miss_req;
   logic [63:0] miss_addr;
   logic        flush_req;
   logic        lru_rd;
   logic [1:0]  valid_rd;
   logic        arvalid;
   logic        arready;
   logic [63:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid;
   logic        rready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        data_we;
   logic [5:0]  data_set;
   logic        data_way;
   logic [2:0]  data_word;
   logic [63:0] data_wdata;
   logic        tag_we;
   logic [5:0]  tag_set;
   logic        tag_way;
   logic [52:0] tag_wdata;
   logic        refill_done;
   logic        refill_err;
   logic        busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   icache_refill_ctrl dut (
      .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_addr(miss_addr),
      .flush_req(flush_req), .lru_rd(lru_rd), .valid_rd(valid_rd),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
      .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .data_we(data_we),
      .data_set(data_set), .data_way(data_way), .data_word(data_word),
      .data_wdata(data_wdata), .tag_we(tag_we), .tag_set(tag_set),
      .tag_way(tag_way), .tag_wdata(tag_wdata), .refill_done(refill_done),
      .refill_err(refill_err), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full miss service; the model derives everything from the address and burst shape.
   task automatic refill(input logic [63:0] addr, input logic [1:0] vrd, input logic lru,
                         input int ar_delay, input int nbeats, input int err_beat);
      logic [5:0]  e_set;
      logic [51:0] e_tag;
      logic        e_way;
      logic        e_err;
      logic [63:0] d;
      e_set = 6'((addr / 64) % 64);
      e_tag = 52'(addr >> 12);
      e_way = (vrd[0] == 1'b0) ? 1'b0 : (vrd[1] == 1'b0) ? 1'b1 : lru;
      e_err = (err_beat < nbeats) || (nbeats != 8);

      @(negedge clk);
      miss_req = 1'b1; miss_addr = addr; valid_rd = vrd; lru_rd = lru;
      #1 chk("idle_busy", busy, 0);

      // INV cycle: victim invalidated; scramble set info to prove it was captured
      @(negedge clk);
      valid_rd = 2'($urandom); lru_rd = 1'($urandom);
      #1;
      chk("inv_we", tag_we, 1);
      chk("inv_set", tag_set, e_set);
      chk("inv_way", tag_way, e_way);
      chk("inv_wdata", tag_wdata, {12'h0, e_tag});
      chk("inv_arvalid", arvalid, 0);

      // address phase, with flush poked while busy to show it is ignored
      for (int k = 0; k <= ar_delay; k++) begin
         @(negedge clk);
         arready = (k == ar_delay);
         flush_req = (k < ar_delay);
         #1;
         chk("ar_valid", arvalid, 1);
         chk("ar_addr", araddr, addr & ~64'h3F);
         chk("ar_len", arlen, 7);
         chk("ar_size_burst", {arsize, arburst}, 5'b01101);
         chk("ar_no_tag", tag_we, 0);
      end

      // data phase
      for (int i = 0; i < nbeats; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            arready = 1'b0; flush_req = 1'b0; rvalid = 1'b0; rlast = 1'b0;
            #1;
            chk("gap_rready", rready, 1);
            chk("gap_we", data_we, 0);
            chk("gap_arvalid", arvalid, 0);
         end
         @(negedge clk);
         arready = 1'b0; flush_req = 1'b0;
         d = {$urandom, $urandom};
         rvalid = 1'b1; rdata = d;
         rresp = (i == err_beat) ? 2'b10 : 2'b00;
         rlast = (i == nbeats - 1);
         #1;
         chk("beat_we", data_we, 1);
         chk("beat_word", data_word, 64'(i % 8));
         chk("beat_way", data_way, e_way);
         chk("beat_set", data_set, e_set);
         chk("beat_wdata", data_wdata, d);
      end

      @(negedge clk);
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      #1;
      if (!e_err) begin
         chk("tag_we", tag_we, 1);
         chk("tag_wdata", tag_wdata, {12'h1, e_tag});
         chk("tag_way", tag_way, e_way);
         chk("tag_set", tag_set, e_set);
         chk("tag_not_done", refill_done, 0);
         @(negedge clk);
         #1;
      end
      chk("done", refill_done, 1);
      chk("done_err", refill_err, e_err);
      chk("done_no_tag", tag_we, 0);
      miss_req = 1'b0;
      @(negedge clk);
      #1;
      chk("after_busy", busy, 0);
      chk("after_done", refill_done, 0);
   endtask

   initial begin
      logic [63:0] a;
      int nb, eb;
      rst_n = 1'b0; miss_req = 1'b0; miss_addr = '0; flush_req = 1'b0;
      lru_rd = 1'b0; valid_rd = '0; arready = 1'b0; rvalid = 1'b0;
      rdata = '0; rresp = '0; rlast = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_arlen", arlen, 7);
      chk("rst_tag_we", tag_we, 0);
      chk("rst_done", refill_done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // nominal refill, all valid -> LRU way 1
      refill(64'h8000_1234, 2'b11, 1'b1, 0, 8, 99);
      // invalid way beats LRU
      refill(64'h8000_1234, 2'b10, 1'b1, 0, 8, 99);
      // slow arready
      refill(64'h0000_0040_dead_beef, 2'b11, 1'b0, 5, 8, 99);
      // error response on beat 3
      refill(64'h1234_5678_9abc_def0, 2'b11, 1'b1, 1, 8, 2);
      // short burst: rlast on beat 5
      refill(64'h0000_0000_0000_1fc0, 2'b00, 1'b1, 0, 5, 99);
      // overlong burst: 10 beats
      refill(64'hffff_ffff_ffff_ffc8, 2'b01, 1'b0, 2, 10, 99);

      // reset mid-burst
      @(negedge clk);
      miss_req = 1'b1; miss_addr = 64'h8000_1234; valid_rd = 2'b11; lru_rd = 1'b1;
      @(negedge clk);
      @(negedge clk);
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0; rvalid = 1'b1; rdata = 64'hA5A5_5A5A_0F0F_F0F0; rlast = 1'b0;
      #1 chk("pre_rst_we", data_we, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rready", rready, 0);
      chk("mid_rst_we", data_we, 0);
      chk("mid_rst_wdata", data_wdata, 0);
      chk("mid_rst_araddr", araddr, 0);
      chk("mid_rst_word", data_word, 0);
      chk("mid_rst_tag", {tag_we, tag_wdata}, 0);
      miss_req = 1'b0; rvalid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst_arvalid", arvalid, 0);
      chk("post_rst_busy", busy, 0);

      // flush and miss together: flush first, miss served afterwards
      a = 64'h0000_0abc_0000_7f80;
      @(negedge clk);
      flush_req = 1'b1; miss_req = 1'b1; miss_addr = a; valid_rd = 2'b01; lru_rd = 1'b0;
      for (int k = 0; k < 128; k++) begin
         @(negedge clk);
         flush_req = 1'b0;
         #1;
         chk("flush_entry", {tag_we, tag_set, tag_way, tag_wdata}, {1'b1, 6'(k / 2), 1'(k % 2), 53'h0});
      end
      @(negedge clk);
      #1;
      chk("flush_done", refill_done, 1);
      chk("flush_err", refill_err, 0);
      refill(a, 2'b01, 1'b0, 0, 8, 99);

      // randomized refills
      for (int r = 0; r < 20; r++) begin
         a = {$urandom, $urandom};
         case ($urandom_range(0, 4))
            0: nb = 5;
            1: nb = 10;
            default: nb = 8;
         endcase
         eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 99;
         refill(a, 2'($urandom), 1'($urandom), int'($urandom_range(0, 3)), nb, eb);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // watchdog so the bench always ends
   initial begin
      #2000000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
